// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and load/store.
// Latency: accept on the ready cycle, mem_req the cycle after, rvalid the cycle after mem_ack (2 cycles minimum).
// Backpressure: one transaction at a time; while busy both readies stay low and requesters hold req.
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT
// consecutive data grants made while a fetch was waiting.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   if_req/if_addr             fetch request (held until if_ready)
//   if_ready/if_rvalid/if_rdata fetch accept, one-cycle completion pulse, instruction word
//   d_req/d_we/d_addr/d_wdata/d_func3  load/store request (held until d_ready)
//   d_ready/d_rvalid/d_rdata   data accept, one-cycle completion pulse, load data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_func3  registered shared memory port
//   mem_ack/mem_rdata          memory completion and read data
//   busy                       a transaction is outstanding
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_func3,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_func3,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   grant_if, grant_d;
  logic   force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  // Counts data grants that overtook a waiting fetch. It never passes STARVE_LIMIT:
  // reaching the limit with both requests pending forces the fetch grant, which clears it.
  logic [3:0] starve_cnt;

  assign force_if = (starve_cnt == 4'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (grant_if) begin
      starve_cnt <= 4'd0;
    end else if (grant_d) begin
      starve_cnt <= if_req ? starve_cnt + 4'd1 : 4'd0;
    end
  end
`else
  assign force_if = 1'b0;

  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration and next state. Grants are gated by rst so the readies read 0
  // the moment reset is asserted, not only after the next edge.
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (if_req && (!d_req || force_if)) begin
            grant_if  = 1'b1;
            state_nxt = FETCH;
          end else if (d_req) begin
            grant_d   = 1'b1;
            state_nxt = DATA;
          end
        end
      end
      FETCH, DATA: begin
        if (mem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign if_ready = grant_if;
  assign d_ready  = grant_d;
  assign busy     = (state != IDLE);
  // Derived straight from the state flop, so it drops asynchronously with rst.
  assign mem_req  = (state != IDLE);

  // Memory port fields are loaded only on a grant and otherwise hold, which keeps
  // them stable for the whole transaction. Read data registers hold between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_func3 <= 3'b000;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;

      if (grant_if) begin
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_func3 <= 3'b010;
      end else if (grant_d) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_func3 <= d_func3;
      end

      if (state == FETCH && mem_ack) begin
        if_rdata  <= mem_rdata;
        if_rvalid <= 1'b1;
      end

      // A store completes with a pulse but leaves d_rdata untouched.
      if (state == DATA && mem_ack) begin
        d_rvalid <= 1'b1;
        if (!mem_we) begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors, corner-case sequences and a random run against
// a transaction-level reference model of mem_port_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are compared 1 unit later.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LIMIT  = 4;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_func3;
  logic              d_ready;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_func3;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_func3(d_func3),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_func3(mem_func3), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " if_ready"},  64'(if_ready),  64'd0);
    chk({tag, " d_ready"},   64'(d_ready),   64'd0);
    chk({tag, " if_rvalid"}, 64'(if_rvalid), 64'd0);
    chk({tag, " d_rvalid"},  64'(d_rvalid),  64'd0);
    chk({tag, " mem_req"},   64'(mem_req),   64'd0);
    chk({tag, " mem_we"},    64'(mem_we),    64'd0);
    chk({tag, " busy"},      64'(busy),      64'd0);
    chk({tag, " mem_addr"},  64'(mem_addr),  64'd0);
    chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, " mem_func3"}, 64'(mem_func3), 64'd0);
    chk({tag, " if_rdata"},  64'(if_rdata),  64'd0);
    chk({tag, " d_rdata"},   64'(d_rdata),   64'd0);
  endtask

  typedef struct {
    logic        if_req;
    logic        d_req;
    logic        d_we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
    logic [31:0] rdata;
    logic        e_if_ready;
    logic        e_d_ready;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [2:0]  e_func3;
    logic [31:0] e_if_rdata;
    logic [31:0] e_d_rdata;
  } vec_t;

  localparam int NV = 7;
  vec_t vec [NV];

  // Reference model state: one outstanding transaction described as plain fields.
  bit          m_busy, m_is_fetch, m_we, m_if_pulse, m_d_pulse;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
  logic [2:0]  m_func3;
  int          m_streak;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            ifq   dq    we    addr          wdata         f3      rdata         eif   ed    ewe   ewdata        ef3     eif_rdata     ed_rdata
    vec[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'hAAAA_AAAA, 3'b111, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 32'h0,         3'b010, 32'h0000_0013, 32'h0};
    vec[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h5555_5555, 3'b010, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 32'h5555_5555, 3'b010, 32'h0000_0013, 32'hCAFE_F00D};
    vec[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 3'b010, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 3'b010, 32'h0000_0013, 32'hCAFE_F00D};
    vec[3] = '{1'b0, 1'b1, 1'b0, 32'h0000_0043, 32'h0,         3'b100, 32'h0000_00EF, 1'b0, 1'b1, 1'b0, 32'h0,         3'b100, 32'h0000_0013, 32'h0000_00EF};
    vec[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h1111_1111, 3'b000, 32'h0010_0093, 1'b1, 1'b0, 1'b0, 32'h0,         3'b010, 32'h0010_0093, 32'h0000_00EF};
    vec[5] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         3'b000, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         3'b000, 32'h0010_0093, 32'h0000_00EF};
    vec[6] = '{1'b0, 1'b1, 1'b1, 32'h0000_2001, 32'h0000_00A5, 3'b000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 32'h0000_00A5, 3'b000, 32'h0010_0093, 32'h0000_00EF};

    // ---------------- reset behaviour ----------------
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h300; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_func3 = 3'b000; mem_ack = 1'b0; mem_rdata = '0;
    #3;
    check_zero("por");
    tick();
    rst = 1'b0; if_req = 1'b0;
    #1;
    if_req = 1'b1;
    #1;
    chk("pre-rst if_ready", 64'(if_ready), 64'd1);
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    tick();
    check_zero("rst_held");
    rst = 1'b0;
    #1;
    chk("post-rst if_ready", 64'(if_ready), 64'd1);
    tick();
    if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0AAA;
    #1;
    chk("post-rst mem_addr", 64'(mem_addr), 64'h300);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("post-rst if_rvalid", 64'(if_rvalid), 64'd1);
    chk("post-rst if_rdata", 64'(if_rdata), 64'h0AAA);

    // ---------------- table-driven single transactions (zero-wait) ----------------
    for (int i = 0; i < NV; i++) begin
      if_req = vec[i].if_req; if_addr = vec[i].addr;
      d_req = vec[i].d_req; d_we = vec[i].d_we; d_addr = vec[i].addr;
      d_wdata = vec[i].wdata; d_func3 = vec[i].func3; mem_ack = 1'b0;
      #1;
      chk($sformatf("v%0d if_ready", i), 64'(if_ready), 64'(vec[i].e_if_ready));
      chk($sformatf("v%0d d_ready", i), 64'(d_ready), 64'(vec[i].e_d_ready));
      tick();
      if_req = 1'b0; d_req = 1'b0;
      if_addr = 32'hFFFF_FFF0; d_addr = 32'hFFFF_FFF0; d_wdata = 32'h0BAD_0BAD; d_func3 = 3'b111;
      if (vec[i].e_if_ready || vec[i].e_d_ready) begin
        mem_ack = 1'b1; mem_rdata = vec[i].rdata;
        #1;
        chk($sformatf("v%0d mem_req", i), 64'(mem_req), 64'd1);
        chk($sformatf("v%0d mem_addr", i), 64'(mem_addr), 64'(vec[i].addr));
        chk($sformatf("v%0d mem_we", i), 64'(mem_we), 64'(vec[i].e_we));
        chk($sformatf("v%0d mem_wdata", i), 64'(mem_wdata), 64'(vec[i].e_wdata));
        chk($sformatf("v%0d mem_func3", i), 64'(mem_func3), 64'(vec[i].e_func3));
        tick();
        mem_ack = 1'b0;
        #1;
        chk($sformatf("v%0d if_rvalid", i), 64'(if_rvalid), 64'(vec[i].e_if_ready));
        chk($sformatf("v%0d d_rvalid", i), 64'(d_rvalid), 64'(vec[i].e_d_ready));
        chk($sformatf("v%0d busy", i), 64'(busy), 64'd0);
      end else begin
        #1;
        chk($sformatf("v%0d idle mem_req", i), 64'(mem_req), 64'd0);
        chk($sformatf("v%0d idle busy", i), 64'(busy), 64'd0);
      end
      chk($sformatf("v%0d if_rdata", i), 64'(if_rdata), 64'(vec[i].e_if_rdata));
      chk($sformatf("v%0d d_rdata", i), 64'(d_rdata), 64'(vec[i].e_d_rdata));
    end

    // ---------------- simultaneous fetch and store ----------------
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_func3 = 3'b010;
    #1;
    chk("sim d_ready", 64'(d_ready), 64'd1);
    chk("sim if_ready", 64'(if_ready), 64'd0);
    tick();
    d_req = 1'b0; d_wdata = '0;
    #1;
    chk("sim mem_we", 64'(mem_we), 64'd1);
    chk("sim mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    chk("sim mem_addr", 64'(mem_addr), 64'h2000);
    chk("sim busy if_ready", 64'(if_ready), 64'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("sim d_rvalid", 64'(d_rvalid), 64'd1);
    chk("sim fetch in rvalid cycle", 64'(if_ready), 64'd1);
    tick();
    if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0093;
    #1;
    chk("sim fetch mem_addr", 64'(mem_addr), 64'h104);
    chk("sim fetch mem_we", 64'(mem_we), 64'd0);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("sim if_rvalid", 64'(if_rvalid), 64'd1);
    chk("sim if_rdata", 64'(if_rdata), 64'h93);

    // ---------------- load with three wait states ----------------
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_func3 = 3'b001; d_wdata = '0;
    if_req = 1'b1; if_addr = 32'h200;
    #1;
    chk("ws d_ready", 64'(d_ready), 64'd1);
    tick();
    d_req = 1'b0; d_addr = 32'h1234; d_func3 = 3'b111;
    for (int w = 0; w < 3; w++) begin
      #1;
      chk($sformatf("ws%0d mem_req", w), 64'(mem_req), 64'd1);
      chk($sformatf("ws%0d mem_addr", w), 64'(mem_addr), 64'h80);
      chk($sformatf("ws%0d mem_func3", w), 64'(mem_func3), 64'd1);
      chk($sformatf("ws%0d mem_we", w), 64'(mem_we), 64'd0);
      chk($sformatf("ws%0d readies", w), 64'({if_ready, d_ready}), 64'd0);
      tick();
    end
    mem_ack = 1'b1; mem_rdata = 32'h0000_BEEF;
    #1;
    chk("ws ack mem_addr", 64'(mem_addr), 64'h80);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("ws d_rvalid", 64'(d_rvalid), 64'd1);
    chk("ws d_rdata", 64'(d_rdata), 64'hBEEF);
    chk("ws fetch accept", 64'(if_ready), 64'd1);
    tick();
    if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    #1;
    chk("ws d_rvalid one pulse", 64'(d_rvalid), 64'd0);
    chk("ws fetch mem_addr", 64'(mem_addr), 64'h200);
    chk("ws fetch mem_func3", 64'(mem_func3), 64'd2);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("ws if_rvalid", 64'(if_rvalid), 64'd1);

    // ---------------- starvation pattern ----------------
    begin
      bit got [10];
      int n = 0;
      if_req = 1'b1; if_addr = 32'h400;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800; d_func3 = 3'b010;
      for (int c = 0; c < 200 && n < 10; c++) begin
        mem_ack = mem_req; mem_rdata = 32'(c);
        #1;
        if (if_ready) begin got[n] = 1'b1; n++; end
        else if (d_ready) begin got[n] = 1'b0; n++; end
        tick();
      end
      chk("starve grant count", 64'(n), 64'd10);
      for (int k = 0; k < 10; k++) begin
        chk($sformatf("starve grant %0d is_fetch", k), 64'(got[k]),
            64'(GUARD && ((k % (LIMIT + 1)) == LIMIT)));
      end
      if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    end

    // ---------------- reset during a stalled data access ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; d_func3 = 3'b010;
    #1;
    chk("rd d_ready", 64'(d_ready), 64'd1);
    tick();
    d_req = 1'b0;
    tick();
    chk("rd stalled mem_req", 64'(mem_req), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rd async mem_req", 64'(mem_req), 64'd0);
    chk("rd async busy", 64'(busy), 64'd0);
    tick();
    tick();
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5A5A_5A5A;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("rd no d_rvalid %0d", c), 64'(d_rvalid), 64'd0);
      tick();
    end
    mem_ack = 1'b0;
    if_req = 1'b1; if_addr = 32'h500;
    #1;
    chk("rd fresh if_ready", 64'(if_ready), 64'd1);
    tick();
    if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0777;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("rd fresh if_rvalid", 64'(if_rvalid), 64'd1);
    chk("rd fresh if_rdata", 64'(if_rdata), 64'h777);
    chk("rd d_rdata unchanged", 64'(d_rdata), 64'd0);

    // ---------------- random traffic against the reference model ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_busy = 1'b0; m_is_fetch = 1'b0; m_we = 1'b0; m_if_pulse = 1'b0; m_d_pulse = 1'b0;
    m_addr = '0; m_wdata = '0; m_func3 = 3'b000; m_if_rdata = '0; m_d_rdata = '0; m_streak = 0;
    for (int c = 0; c < 400; c++) begin
      bit g_if, g_d;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = $urandom;
        d_wdata = $urandom; d_func3 = 3'($urandom);
      end
      mem_ack = ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
      #1;
      g_if = !m_busy && if_req && (!d_req || (GUARD && m_streak == LIMIT));
      g_d  = !m_busy && d_req && !g_if;
      chk($sformatf("rnd%0d if_ready", c), 64'(if_ready), 64'(g_if));
      chk($sformatf("rnd%0d d_ready", c), 64'(d_ready), 64'(g_d));
      chk($sformatf("rnd%0d busy", c), 64'(busy), 64'(m_busy));
      chk($sformatf("rnd%0d mem_req", c), 64'(mem_req), 64'(m_busy));
      chk($sformatf("rnd%0d mem_addr", c), 64'(mem_addr), 64'(m_addr));
      chk($sformatf("rnd%0d mem_we", c), 64'(mem_we), 64'(m_we));
      chk($sformatf("rnd%0d mem_wdata", c), 64'(mem_wdata), 64'(m_wdata));
      chk($sformatf("rnd%0d mem_func3", c), 64'(mem_func3), 64'(m_func3));
      chk($sformatf("rnd%0d if_rvalid", c), 64'(if_rvalid), 64'(m_if_pulse));
      chk($sformatf("rnd%0d d_rvalid", c), 64'(d_rvalid), 64'(m_d_pulse));
      chk($sformatf("rnd%0d if_rdata", c), 64'(if_rdata), 64'(m_if_rdata));
      chk($sformatf("rnd%0d d_rdata", c), 64'(d_rdata), 64'(m_d_rdata));
      // advance the model across the clock edge
      m_if_pulse = 1'b0;
      m_d_pulse  = 1'b0;
      if (m_busy && mem_ack) begin
        if (m_is_fetch) begin
          m_if_rdata = mem_rdata; m_if_pulse = 1'b1;
        end else begin
          m_d_pulse = 1'b1;
          if (!m_we) m_d_rdata = mem_rdata;
        end
        m_busy = 1'b0;
      end else if (g_if) begin
        m_busy = 1'b1; m_is_fetch = 1'b1; m_addr = if_addr; m_we = 1'b0;
        m_wdata = '0; m_func3 = 3'b010; m_streak = 0;
      end else if (g_d) begin
        m_busy = 1'b1; m_is_fetch = 1'b0; m_addr = d_addr; m_we = d_we;
        m_wdata = d_wdata; m_func3 = d_func3;
        m_streak = if_req ? m_streak + 1 : 0;
      end
      tick();
      if (g_if) if_req = 1'b0;
      if (g_d)  d_req  = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
